// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
// The master side requests transfers; the slave side (the transmitter) drives the serial stream.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, repeat_n,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, repeat_n,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB first, repeat_n times back to back,
// then pulses done for one cycle. Abort or reset drops the transfer without a done pulse.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_tx_if.slave  bus
);

  localparam int BCW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          pat_d     = bus.pattern;
          shift_d   = bus.pattern;
          rep_d     = bus.repeat_n;
          bit_cnt_d = '0;
          state_d   = (bus.repeat_n != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d   = IDLE;
          shift_d   = '0;
          bit_cnt_d = '0;
          rep_d     = '0;
        end else if (bit_cnt_q == LAST_BIT) begin
          // End of one copy: reload the saved pattern for the next copy, or finish.
          bit_cnt_d = '0;
          rep_d     = rep_q - 1'b1;
          if (rep_q == CNT_W'(1)) begin
            state_d = DONE;
            shift_d = '0;
          end else begin
            shift_d = pat_q;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d   = {shift_q[PAT_W-2:0], 1'b0};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_d       = (state_d == SHIFT) && shift_d[PAT_W-1];
    out_valid_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      pat_q       <= '0;
      bit_cnt_q   <= '0;
      rep_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pat_q       <= pat_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_q       <= rep_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
